mmio_uart: RTL and testbench

- Memory-mapped hardware UART (8N1) with parametrised TX/RX FIFOs and a run-time programmable bit divider.
- Successor to the software bit-banged TX/RX pins in the board wrappers.
- Sits on the pipeline's data bus behind the wrapper's I/O address decode.
- Frees the core from bit timing, buffers bursts in both directions, and reports errors and status.

---
 rtl/mmio_uart.sv | 228 ++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart.sv
// mmio_uart: memory-mapped 8N1 UART with TX/RX FIFOs and a run-time programmable bit divider.
// Define MMIO_UART_IRQ_EN to add the IEN register (addr 3) and a live interrupt output.
module mmio_uart #(
  parameter int unsigned CLOCK_RATE = 12_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [DIV_WIDTH-1:0] ResetDiv = DIV_WIDTH'(CLOCK_RATE / BAUD_RATE);
  localparam logic [DIV_WIDTH-1:0] MinDiv = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] One = DIV_WIDTH'(1);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic wr, rd;
  assign wr = req_valid & req_write;
  assign rd = req_valid & ~req_write;

  logic [DIV_WIDTH-1:0] div_q, div_wr;
  logic overrun_q, frame_q;
  assign div_wr = req_wdata[DIV_WIDTH-1:0];

  // TX FIFO
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW:0] tx_wptr_q, tx_rptr_q;
  logic tx_full, tx_empty, tx_push, tx_pop, tx_busy, tx_tick;
  assign tx_empty = tx_wptr_q == tx_rptr_q;
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);

  // RX FIFO
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wptr_q, rx_rptr_q;
  logic rx_full, rx_empty, rx_push, rx_pop, rx_tick, rx_stop_smp;
  assign rx_empty = rx_wptr_q == rx_rptr_q;
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

  // TX FSM
  state_e tx_state_q;
  logic [DIV_WIDTH-1:0] tx_cnt_q;
  logic [2:0] tx_bit_q;
  logic [7:0] tx_shift_q;
  assign tx_busy = tx_state_q != StIdle;
  assign tx_tick = tx_cnt_q == '0;
  assign tx_pop  = ~tx_empty & ((tx_state_q == StIdle) | ((tx_state_q == StStop) & tx_tick));
  assign tx_push = wr & (req_addr == 2'd0) & (~tx_full | tx_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      uart_tx    <= 1'b1;
    end else if (tx_pop) begin
      // Covers both leaving IDLE and back-to-back frames from the end of STOP.
      tx_state_q <= StStart;
      tx_cnt_q   <= div_q - One;
      tx_shift_q <= tx_mem[tx_rptr_q[AW-1:0]];
      uart_tx    <= 1'b0;
    end else if (tx_busy) begin
      if (!tx_tick) begin
        tx_cnt_q <= tx_cnt_q - One;
      end else begin
        tx_cnt_q <= div_q - One;
        unique case (tx_state_q)
          StStart: begin
            tx_state_q <= StData;
            tx_bit_q   <= '0;
            uart_tx    <= tx_shift_q[0];
          end
          StData: begin
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= StStop;
              uart_tx    <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= tx_shift_q >> 1;
              uart_tx    <= tx_shift_q[1];
            end
          end
          default: tx_state_q <= StIdle;
        endcase
      end
    end
  end

  // RX synchroniser and FSM
  logic rx_s1_q, rx_s2_q, rx_prev_q;
  state_e rx_state_q;
  logic [DIV_WIDTH-1:0] rx_cnt_q;
  logic [2:0] rx_bit_q;
  logic [7:0] rx_shift_q;
  logic overrun_set, frame_set;
  assign rx_tick     = rx_cnt_q == '0;
  assign rx_stop_smp = (rx_state_q == StStop) & rx_tick;
  assign rx_pop      = rd & (req_addr == 2'd0) & ~rx_empty;
  assign rx_push     = rx_stop_smp & rx_s2_q & (~rx_full | rx_pop);
  assign overrun_set = rx_stop_smp & rx_s2_q & rx_full & ~rx_pop;
  assign frame_set   = rx_stop_smp & ~rx_s2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      unique case (rx_state_q)
        StIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= StStart;
            rx_cnt_q   <= (div_q >> 1) - One;
          end
        end
        StStart: begin
          if (!rx_tick) begin
            rx_cnt_q <= rx_cnt_q - One;
          end else if (rx_s2_q) begin
            rx_state_q <= StIdle;
          end else begin
            rx_state_q <= StData;
            rx_cnt_q   <= div_q - One;
            rx_bit_q   <= '0;
          end
        end
        StData: begin
          if (!rx_tick) begin
            rx_cnt_q <= rx_cnt_q - One;
          end else begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_cnt_q   <= div_q - One;
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= StStop;
          end
        end
        default: begin
          if (!rx_tick) rx_cnt_q <= rx_cnt_q - One;
          else rx_state_q <= StIdle;
        end
      endcase
    end
  end

  // FIFO pointers, registers and sticky flags; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      div_q     <= ResetDiv;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrOne;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrOne;
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrOne;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrOne;
      if (wr && req_addr == 2'd2) div_q <= (div_wr < MinDiv) ? MinDiv : div_wr;
      overrun_q <= overrun_set | (overrun_q & ~(wr & (req_addr == 2'd1) & req_wdata[4]));
      frame_q   <= frame_set | (frame_q & ~(wr & (req_addr == 2'd1) & req_wdata[5]));
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q[AW-1:0]] <= req_wdata[7:0];
    if (rx_push) rx_mem[rx_wptr_q[AW-1:0]] <= rx_shift_q;
  end

  logic [31:0] ien_rd;
`ifdef MMIO_UART_IRQ_EN
  logic [1:0] ien_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ien_q <= '0;
      irq   <= 1'b0;
    end else begin
      if (wr && req_addr == 2'd3) ien_q <= req_wdata[1:0];
      irq <= (ien_q[0] & ~rx_empty) | (ien_q[1] & tx_empty & ~tx_busy) | overrun_q | frame_q;
    end
  end
  assign ien_rd = {30'b0, ien_q};
`else
  assign ien_rd = '0;
  assign irq    = 1'b0;
`endif

  logic [31:0] rdata_d;
  logic [6:0] status;
  assign status = {tx_busy, frame_q, overrun_q, rx_full, rx_empty, tx_empty, tx_full};

  always_comb begin
    rdata_d = '0;
    unique case (req_addr)
      2'd0: if (!rx_empty) rdata_d = {23'b0, 1'b1, rx_mem[rx_rptr_q[AW-1:0]]};
      2'd1: rdata_d = {25'b0, status};
      2'd2: rdata_d = 32'(div_q);
      default: rdata_d = ien_rd;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata <= '0;
    else if (rd) rdata <= rdata_d;
  end

  logic unused_wdata;
  assign unused_wdata = ^req_wdata;
endmodule

// File: tb/tb_mmio_uart.sv
// Bench for mmio_uart: register reads scored against a bench model, TX line decoded by a monitor,
// RX frames injected on uart_rx with a reference RX FIFO model.
module tb_mmio_uart;
  localparam int unsigned Depth = 4;
`ifdef MMIO_UART_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] rdata;
  logic        uart_rx, uart_tx, irq;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b0;

  int bdiv = 104;
  int checks = 0;
  int failures = 0;
  logic [31:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rx_q[$];
  time         start_q[$];
  logic        exp_ovr = 1'b0;
  logic        exp_frm = 1'b0;

  always #5 clk = ~clk;
  assign uart_rx = loopback ? uart_tx : rx_drv;

  mmio_uart #(.FIFO_DEPTH(Depth)) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rdata    (rdata),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    data = rdata;
  endtask

  task automatic expect_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    rd_exp_q.push_back(exp);
    bus_read(addr, d);
    check(tag, d, rd_exp_q.pop_front());
  endtask

  function automatic logic [31:0] status_exp(input logic busy, input logic tx_empty,
                                             input logic tx_full);
    return {25'b0, busy, exp_frm, exp_ovr, rx_q.size() == Depth, rx_q.size() == 0,
            tx_empty, tx_full};
  endfunction

  task automatic check_status(input string tag, input logic busy, input logic tx_empty,
                              input logic tx_full);
    expect_read(tag, 2'd1, status_exp(busy, tx_empty, tx_full));
  endtask

  task automatic read_data(input string tag);
    logic [31:0] e;
    e = (rx_q.size() != 0) ? {23'b0, 1'b1, rx_q.pop_front()} : 32'h0;
    expect_read(tag, 2'd0, e);
  endtask

  task automatic drive_bit(input logic v);
    rx_drv = v;
    repeat (bdiv) @(posedge clk);
    #1;
  endtask

  task automatic inject(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok);
    drive_bit(1'b1);
    if (!stop_ok) exp_frm = 1'b1;
    else if (rx_q.size() < Depth) rx_q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (tx_exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("tx_drain", tx_exp_q.size(), 0);
  endtask

  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      start_q.push_back($time);
      repeat (bdiv / 2) @(posedge clk);
      #1 check("tx_start", uart_tx, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (bdiv) @(posedge clk);
        #1 b[i] = uart_tx;
      end
      repeat (bdiv) @(posedge clk);
      #1 check("tx_stop", uart_tx, 1);
      if (tx_exp_q.size() == 0) check("tx_extra", b, 32'h100);
      else check("tx_byte", b, tx_exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_uart_tx", uart_tx, 1);
    check("reset_rdata", rdata, 0);
    check("reset_irq", irq, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    expect_read("reset_div", 2'd2, 104);
    check_status("reset_status", 0, 1, 0);
    expect_read("reset_ien", 2'd3, 0);

    // Back-to-back TX frames
    bus_write(2'd2, 8);
    bdiv = 8;
    expect_read("div_8", 2'd2, 8);
    start_q.delete();
    tx_exp_q.push_back(8'h55);
    bus_write(2'd0, 32'h55);
    tx_exp_q.push_back(8'hA3);
    bus_write(2'd0, 32'hA3);
    repeat (4) @(posedge clk);
    #1;
    bus_read(2'd1, d);
    check("tx_busy_mid", d[6], 1);
    wait_tx_drain(400);
    repeat (8) @(posedge clk);
    #1;
    check_status("tx_idle_after_burst", 0, 1, 0);
    check("tx_frames", start_q.size(), 2);
    if (start_q.size() >= 2) check("tx_no_gap", 32'(start_q[1] - start_q[0]), 800);

    // Loopback
    loopback = 1'b1;
    tx_exp_q.push_back(8'h3C);
    rx_q.push_back(8'h3C);
    bus_write(2'd0, 32'h3C);
    wait_tx_drain(200);
    repeat (12) @(posedge clk);
    #1;
    check_status("loop_status", 0, 1, 0);
    read_data("loop_data");
    read_data("loop_empty");
    loopback = 1'b0;

    // Overrun
    for (int i = 1; i <= 5; i++) inject(8'(i), 1'b1);
    check_status("ovr_status", 0, 1, 0);
    check("ovr_irq", irq, IrqEn);
    for (int i = 0; i < Depth; i++) read_data("ovr_data");
    check_status("ovr_drained", 0, 1, 0);
    bus_write(2'd1, 32'h10);
    exp_ovr = 1'b0;
    check_status("ovr_cleared", 0, 1, 0);
    check("ovr_irq_clear", irq, 0);

    // Frame error, then glitch rejection
    inject(8'h7E, 1'b0);
    check_status("frm_status", 0, 1, 0);
    read_data("frm_nopush");
    bus_write(2'd1, 32'h20);
    exp_frm = 1'b0;
    check_status("frm_cleared", 0, 1, 0);
    rx_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_status("glitch_status", 0, 1, 0);
    read_data("glitch_nodata");
    inject(8'h5A, 1'b1);
    read_data("after_glitch");

    // Divider clamp and width
    bus_write(2'd2, 1);
    expect_read("div_clamp1", 2'd2, 4);
    bus_write(2'd2, 0);
    expect_read("div_clamp0", 2'd2, 4);
    bus_write(2'd2, 32'hFFFF_0005);
    expect_read("div_width", 2'd2, 5);
    bus_write(2'd2, 4);
    bdiv = 4;

    // TX FIFO full: one byte in the shifter plus Depth queued, the last write is dropped
    start_q.delete();
    for (int i = 0; i < Depth + 2; i++) begin
      if (i < Depth + 1) tx_exp_q.push_back(8'hB0 + 8'(i));
      bus_write(2'd0, 32'hB0 + 32'(i));
    end
    check_status("tx_full_status", 1, 0, 1);
    wait_tx_drain(400);
    repeat (60) @(posedge clk);
    #1;
    check_status("tx_full_done", 0, 1, 0);
    check("tx_full_frames", start_q.size(), Depth + 1);

    // Interrupt enable
    bus_write(2'd3, 2);
    repeat (2) @(posedge clk);
    #1;
    check("ien_irq", irq, IrqEn);
    expect_read("ien_read", 2'd3, IrqEn ? 32'd2 : 32'd0);
    bus_write(2'd3, 0);
    repeat (2) @(posedge clk);
    #1;
    check("ien_irq_off", irq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
